// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two data-memory requesters, the arbiter and the data memory.
// The arbiter connects through the slave modport; the requester/memory side uses master.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic              req0;
  logic              req1;
  logic              we0;
  logic              we1;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata0;
  logic [DATA_W-1:0] wdata1;
  logic              gnt0;
  logic              gnt1;
  logic              rvalid0;
  logic              rvalid1;
  logic [DATA_W-1:0] rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_write_data;
  logic              mem_read;
  logic              mem_write;
  logic [DATA_W-1:0] mem_read_data;
  logic              busy;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_read_data,
    output gnt0, gnt1, rvalid0, rvalid1, rdata,
           mem_addr, mem_write_data, mem_read, mem_write, busy
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_read_data,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata,
           mem_addr, mem_write_data, mem_read, mem_write, busy
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer for the single-port data memory (IDLE -> CMD -> RESP).
// Define DMEM_ARB_ROUND_ROBIN_EN for round-robin ties; otherwise port 0 has fixed priority.
module dmem_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic           clk,
  input  logic           reset,
  dmem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              winner_q, winner_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              win1;

`ifdef DMEM_ARB_ROUND_ROBIN_EN
  logic              last_q, last_d;

  // On a tie the port not recorded in last_q wins.
  always_comb begin
    win1 = bus.req1 & (~bus.req0 | ~last_q);
  end
`else
  always_comb begin
    win1 = bus.req1 & ~bus.req0;
  end
`endif

  always_comb begin
    state_d     = state_q;
    winner_d    = winner_q;
    we_d        = we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
    last_d      = last_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.req0 | bus.req1) begin
          winner_d    = win1;
          we_d        = win1 ? bus.we1    : bus.we0;
          mem_addr_d  = win1 ? bus.addr1  : bus.addr0;
          mem_wdata_d = win1 ? bus.wdata1 : bus.wdata0;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
          last_d      = win1;
`endif
          state_d     = CMD;
        end
      end
      CMD: begin
        state_d = we_q ? IDLE : RESP;
      end
      RESP: begin
        rdata_d = bus.mem_read_data;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      winner_q    <= 1'b0;
      we_q        <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
      last_q      <= 1'b1;
`endif
    end else begin
      state_q     <= state_d;
      winner_q    <= winner_d;
      we_q        <= we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
      last_q      <= last_d;
`endif
    end
  end

  assign bus.gnt0           = (state_q == CMD) & ~winner_q;
  assign bus.gnt1           = (state_q == CMD) &  winner_q;
  assign bus.mem_read       = (state_q == CMD) & ~we_q;
  assign bus.mem_write      = (state_q == CMD) &  we_q;
  assign bus.mem_addr       = mem_addr_q;
  assign bus.mem_write_data = mem_wdata_q;
  assign bus.busy           = (state_q != IDLE);

  // Memory data arrives during RESP; a reset landing in RESP suppresses the response.
  assign bus.rvalid0 = (state_q == RESP) & ~winner_q & ~reset;
  assign bus.rvalid1 = (state_q == RESP) &  winner_q & ~reset;
  assign bus.rdata   = (state_q == RESP) ? bus.mem_read_data : rdata_q;

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and sequencer for the single-port data memory (8-bit word address, 32-bit data). Port 0 carries the processor's load/store traffic; port 1 carries the loader/debug path that preloads or inspects data memory. The block serialises both requesters onto the memory's `mem_read`/`mem_write` controls, issues one registered memory command per transaction, and routes read data back to the winning port.

## Interface
- `ADDR_W`, 8: data memory address width.
- `DATA_W`, 32: data width.

- `clk` input 1: single clock; all state updates on its rising edge.
- `reset` input 1: synchronous, active-high.
- `req0`, `req1` input 1: transaction request from port 0 / port 1.
- `we0`, `we1` input 1: 1 = write, 0 = read.
- `addr0`, `addr1` input ADDR_W: word address.
- `wdata0`, `wdata1` input DATA_W: write data.
- `gnt0`, `gnt1` output 1: one-cycle pulse; the command is on the memory bus this cycle.
- `rvalid0`, `rvalid1` output 1: one-cycle pulse; `rdata` is valid for that port.
- `rdata` output DATA_W: read data, shared by both ports and qualified by `rvalid*`.
- `mem_addr` output ADDR_W: to data memory `addr`.
- `mem_write_data` output DATA_W: to data memory `write_data`.
- `mem_read`, `mem_write` output 1: to data memory controls.
- `mem_read_data` input DATA_W: from data memory. Valid the cycle after `mem_read`.
- `busy` output 1: high in any state other than IDLE.

## Operation
- **States.** IDLE, CMD, RESP.
- **IDLE.** Sample `req0`/`req1`.
  - No request: stay in IDLE.
  - One request: that port wins.
  - Both requesting: the arbitration policy decides (see Configuration).
  - On a win: latch `winner`, `we`, `addr`, `wdata` into command registers, then go to CMD.
- **CMD.** Drive the registered `mem_addr` and `mem_write_data`. Assert `mem_write` if we=1, otherwise `mem_read`. Pulse `gnt<winner>`.
  - Write: next state IDLE.
  - Read: next state RESP.
- **RESP.** Register `mem_read_data` into `rdata` and pulse `rvalid<winner>`. Next state IDLE.
- **Requester rules.**
  - Hold `req`, `we`, `addr` and `wdata` stable from assertion until `gnt`.
  - In the cycle after `gnt`, either deassert `req` or present the next transaction. A `req` still high when the arbiter is next in IDLE counts as a new transaction.
  - `req` may be withdrawn before `gnt`. Only IDLE samples requests, so a withdrawn request is never granted.
- **Mutual exclusion.**
  - `gnt0` and `gnt1` are never high together.
  - `rvalid0` and `rvalid1` are never high together.
  - `mem_read` and `mem_write` are never high together.
- **Idle outputs.** `mem_addr` and `mem_write_data` hold their last value when idle. `mem_read` and `mem_write` are 0 outside CMD.
- **Reset values.**
  - state IDLE.
  - `gnt*`, `rvalid*`, `mem_read`, `mem_write`, `busy` = 0.
  - `rdata`, `mem_addr`, `mem_write_data` = 0.
  - Round-robin pointer `last` = 1, so port 0 wins the first tie.
- **Reset mid-operation.** Any in-flight transaction is dropped and no `gnt`/`rvalid` follows. A read in RESP when reset hits produces no `rvalid`. Memory state is untouched except for a write already issued in CMD.

## Timing
- Request seen in IDLE at cycle N. `gnt` and memory command at N+1.
- Read data: `rvalid` at N+2.
- Next arbitration decision:
  - N+2 after a write, so the next `gnt` is at N+3.
  - N+3 after a read, so the next `gnt` is at N+4.
- Peak throughput: one write per 2 cycles, one read per 3 cycles.
- Addresses are used as given, with no wrap or offset. Out-of-range handling belongs to data memory.
- Fairness: with the round-robin macro enabled, a continuously requesting port waits at most one other transaction.

## Configuration
- `DMEM_ARB_ROUND_ROBIN_EN` defined:
  - On a tie, the port not recorded in `last` wins.
  - `last` updates to the winner on every grant decision.
- `DMEM_ARB_ROUND_ROBIN_EN` undefined:
  - Fixed priority, port 0 always wins ties.
  - `last` is not implemented.
  - Port 1 can starve under continuous port-0 traffic; this is accepted for normal run mode, where the loader is quiet.

## Test plan
- **Reset then single write.** After reset, port 0 writes addr 0x10, data 0xDEADBEEF.
  - Expect `gnt0`, `mem_write` and `mem_addr`=0x10 at N+1, `busy` 1 for one cycle, back in IDLE at N+2.
- **Read back.** Port 1 reads addr 0x10.
  - Expect `gnt1`, `mem_read` at N+1, then `rvalid1` and `rdata`=0xDEADBEEF at N+2, with `rvalid0` = 0 throughout.
- **Simultaneous requests, round-robin build.** Both ports continuously request writes (port 0 to 0x01, port 1 to 0x02).
  - Expect grant order 0,1,0,1 at cycles N+1, N+3, N+5, N+7.
  - Fixed-priority build: grants 0,0,0,0.
- **Reset mid-read.** `reset` is asserted in the RESP cycle of a port-0 read.
  - Expect no `rvalid0`; all outputs 0 the next cycle; the next request is granted normally.
- **Request withdrawal.** Port 1 raises `req1` while a port-0 read is in CMD, then drops it in RESP.
  - Expect no `gnt1`; the arbiter returns to IDLE with `busy` = 0.
- **Exclusion checker.** Over 1000 random request cycles, `gnt0&gnt1`, `mem_read&mem_write` and `rvalid0&rvalid1` are never 1.
  - Every `gnt` for a read is followed by exactly one `rvalid` one cycle later.
  - Every `rdata` matches a reference memory model.
